// File: rtl/axi_pkg.sv
// Shared AXI-Lite types and default bus widths used by the CSR endpoint.
package axi_pkg;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } respCode;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Register index width; a single-register bank still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Byte address to register index decode for the CSR bank; low byte-lane bits are ignored.
module axil_addr_decode
  import axi_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = axi_pkg::ADDRESS_WIDTH,
  parameter int unsigned              DATA_WIDTH    = axi_pkg::DATA_WIDTH,
  parameter int unsigned              NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  localparam int unsigned             IDX_W         = idx_width(NUM_REGS)
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     hit_c,
  output logic [IDX_W-1:0]         idx_c
);

  localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [ADDRESS_WIDTH-1:0] word;

  // Word offset from the bank base; anything below the base wraps and is rejected by the compare.
  always_comb begin
    offset = addr - BASE_ADDR;
    word   = offset >> OFF_W;
    hit_c  = (addr >= BASE_ADDR) && (word < ADDRESS_WIDTH'(NUM_REGS));
    idx_c  = IDX_W'(word);
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI-Lite CSR register bank with independent AW/W capture, per-register read-only mask
// and one-cycle write strobes exported to user logic.
module axil_reg_slave
  import axi_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = axi_pkg::ADDRESS_WIDTH,
  parameter int unsigned              DATA_WIDTH    = axi_pkg::DATA_WIDTH,
  parameter int unsigned              NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter logic [NUM_REGS-1:0]      RO_MASK       = '0,
  localparam int unsigned             STRB_WIDTH    = DATA_WIDTH / 8,
  localparam int unsigned             IDX_W         = idx_width(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           ARESET,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [STRB_WIDTH-1:0]          WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  output respCode                        BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output respCode                        RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic                  aw_hit_q, aw_hit_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  awready_d, wready_d, bvalid_d;
  respCode               bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_d;

  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_d, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  respCode               rresp_d;

  logic                  aw_hit_c, ar_hit_c;
  logic [IDX_W-1:0]      aw_idx_c, ar_idx_c;
  logic                  aw_hs_c, w_hs_c, ar_hs_c;

  axil_addr_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .BASE_ADDR     (BASE_ADDR)
  ) u_aw_decode (
    .addr  (AWADDR),
    .hit_c (aw_hit_c),
    .idx_c (aw_idx_c)
  );

  axil_addr_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .BASE_ADDR     (BASE_ADDR)
  ) u_ar_decode (
    .addr  (ARADDR),
    .hit_c (ar_hit_c),
    .idx_c (ar_idx_c)
  );

  assign aw_hs_c = AWVALID && AWREADY;
  assign w_hs_c  = WVALID && WREADY;
  assign ar_hs_c = ARVALID && ARREADY;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  // Write path: collect AW and W independently, commit once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_hit_d   = aw_hit_q;
    aw_idx_d   = aw_idx_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = BVALID;
    bresp_d    = BRESP;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    unique case (wr_state_q)
      W_COLLECT: begin
        if (aw_hs_c) begin
          aw_held_d = 1'b1;
          aw_hit_d  = aw_hit_c;
          aw_idx_d  = aw_idx_c;
        end
        if (w_hs_c) begin
          w_held_d = 1'b1;
          w_data_d = WDATA;
          w_strb_d = WSTRB;
        end
        if (aw_held_q && w_held_q) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
          if (!aw_hit_q) begin
            bresp_d = DECERR;
          end else if (RO_MASK[aw_idx_q]) begin
            bresp_d = SLVERR;
          end else begin
            bresp_d              = OKAY;
            wr_pulse_d[aw_idx_q] = 1'b1;
            for (int k = 0; k < STRB_WIDTH; k++) begin
              if (w_strb_q[k]) begin
                regs_d[aw_idx_q][k*8 +: 8] = w_data_q[k*8 +: 8];
              end
            end
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_COLLECT;
        end
      end
      default: wr_state_d = W_COLLECT;
    endcase

    awready_d = (wr_state_d == W_COLLECT) && !aw_held_d;
    wready_d  = (wr_state_d == W_COLLECT) && !w_held_d;
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      wr_state_q <= W_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_hit_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      AWREADY    <= 1'b0;
      WREADY     <= 1'b0;
      BVALID     <= 1'b0;
      BRESP      <= OKAY;
      wr_pulse   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_hit_q   <= aw_hit_d;
      aw_idx_q   <= aw_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      AWREADY    <= awready_d;
      WREADY     <= wready_d;
      BVALID     <= bvalid_d;
      BRESP      <= bresp_d;
      wr_pulse   <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  // Read path: sample the bank at the AR handshake, so a same-edge commit is not visible yet.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = RVALID;
    rdata_d    = RDATA;
    rresp_d    = RRESP;

    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rvalid_d   = 1'b1;
          rd_state_d = R_RESP;
          if (ar_hit_c) begin
            rdata_d = regs_q[ar_idx_c];
            rresp_d = OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = DECERR;
          end
        end
      end
      R_RESP: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      ARREADY    <= 1'b0;
      RVALID     <= 1'b0;
      RDATA      <= '0;
      RRESP      <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      ARREADY    <= arready_d;
      RVALID     <= rvalid_d;
      RDATA      <= rdata_d;
      RRESP      <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed plus randomized bench for axil_reg_slave against an array-based register model.
module tb_axil_reg_slave;
  import axi_pkg::*;

  localparam int unsigned   NREGS = 16;
  localparam logic [31:0]   BASE  = 32'h0000_1000;
  localparam logic [15:0]   RO    = 16'h0022;

  logic         clk;
  logic         ARESET;
  logic         AWVALID, AWREADY;
  logic [31:0]  AWADDR;
  logic         WVALID, WREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         BVALID, BREADY;
  respCode      BRESP;
  logic         ARVALID, ARREADY;
  logic [31:0]  ARADDR;
  logic         RVALID, RREADY;
  logic [31:0]  RDATA;
  respCode      RRESP;
  logic [NREGS*32-1:0] reg_q;
  logic [NREGS-1:0]    wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [NREGS];

  axil_reg_slave #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .NUM_REGS      (NREGS),
    .BASE_ADDR     (BASE),
    .RO_MASK       (RO)
  ) dut (
    .clk      (clk),
    .ARESET   (ARESET),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWADDR   (AWADDR),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .ARADDR   (ARADDR),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [511:0] obs, input logic [511:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: word index, response and read data derived from the address arithmetic.
  function automatic bit in_range(input logic [31:0] a);
    if (a < BASE) return 1'b0;
    return ((a - BASE) / 32'd4) < 32'(NREGS);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic respCode mdl_resp(input logic [31:0] a, input bit wr);
    logic [15:0] ro_v;
    ro_v = RO;
    if (!in_range(a)) return DECERR;
    if (wr && ro_v[widx(a)]) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [511:0] mdl_packed();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;
  endtask

  task automatic send_aw(input logic [31:0] a, input int d);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    repeat (d) begin @(posedge clk); #1; end
    AWVALID = 1'b1;
    AWADDR  = a;
    while (!hs && n < 20) begin
      hs = AWREADY;
      @(posedge clk); #1;
      n++;
    end
    AWVALID = 1'b0;
    if (!hs) chk(512'(hs), 512'(1), "aw_handshake_timeout");
  endtask

  task automatic send_w(input logic [31:0] dat, input logic [3:0] strb, input int d);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    repeat (d) begin @(posedge clk); #1; end
    WVALID = 1'b1;
    WDATA  = dat;
    WSTRB  = strb;
    while (!hs && n < 20) begin
      hs = WREADY;
      @(posedge clk); #1;
      n++;
    end
    WVALID = 1'b0;
    if (!hs) chk(512'(hs), 512'(1), "w_handshake_timeout");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] strb,
                          input int awd, input int wd, input int stall);
    respCode          er;
    logic [NREGS-1:0] ep;
    int               n;
    er = mdl_resp(a, 1'b1);
    ep = '0;
    if (er == OKAY) ep[widx(a)] = 1'b1;
    fork
      send_aw(a, awd);
      send_w(dat, strb, wd);
    join
    n = 0;
    while (!BVALID && n < 10) begin @(posedge clk); #1; n++; end
    chk(512'(n), 512'(1), "b_latency");
    chk(512'(BRESP), 512'(er), "bresp");
    chk(512'(wr_pulse), 512'(ep), "wr_pulse");
    if (er == OKAY) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) mdl[widx(a)][k*8 +: 8] = dat[k*8 +: 8];
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk(512'({BVALID, BRESP, AWREADY, WREADY, wr_pulse}),
          512'({1'b1, er, 1'b0, 1'b0, {NREGS{1'b0}}}), "b_stall_hold");
    end
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
    chk(512'(BVALID), 512'(0), "bvalid_drop");
    chk(reg_q, mdl_packed(), "reg_q");
  endtask

  task automatic do_read(input logic [31:0] a, input int d, input int stall);
    logic [31:0] ed;
    respCode     er;
    bit          hs;
    int          n;
    hs = 1'b0;
    n  = 0;
    ed = '0;
    er = OKAY;
    repeat (d) begin @(posedge clk); #1; end
    ARVALID = 1'b1;
    ARADDR  = a;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = ARREADY;
      er = mdl_resp(a, 1'b0);
      ed = (er == OKAY) ? mdl[widx(a)] : 32'h0;
      @(posedge clk); #1;
      n++;
    end
    ARVALID = 1'b0;
    if (!hs) chk(512'(hs), 512'(1), "ar_handshake_timeout");
    n = 0;
    while (!RVALID && n < 10) begin @(posedge clk); #1; n++; end
    chk(512'(RVALID), 512'(1), "rvalid");
    chk(512'({RDATA, RRESP}), 512'({ed, er}), "rdata_rresp");
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk(512'({RVALID, ARREADY, RDATA, RRESP}), 512'({1'b1, 1'b0, ed, er}), "r_stall_hold");
    end
    RREADY = 1'b1;
    @(posedge clk); #1;
    RREADY = 1'b0;
    chk(512'(RVALID), 512'(0), "rvalid_drop");
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r == 19) return BASE - 32'd4;
    return BASE + 32'(r) * 32'd4 + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    ARESET  = 1'b1;
    AWVALID = 1'b0; AWADDR = '0;
    WVALID  = 1'b0; WDATA  = '0; WSTRB = '0;
    BREADY  = 1'b0;
    ARVALID = 1'b0; ARADDR = '0;
    RREADY  = 1'b0;
    mdl_clear();

    repeat (3) begin @(posedge clk); #1; end
    chk(512'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, wr_pulse}),
        512'(0), "reset_outputs");
    chk(reg_q, 512'(0), "reset_regs");
    ARESET = 1'b0;
    @(posedge clk); #1;
    chk(512'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 512'(5'b11100), "ready_after_reset");

    // Same-cycle AW/W, then W three cycles ahead of AW with partial strobes.
    do_write(BASE + 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 2);
    chk(512'(reg_q[2*32 +: 32]), 512'(32'hDEADBEEF), "reg2_full");
    do_write(BASE + 32'h8, 32'h11223344, 4'b0101, 3, 0, 1);
    chk(512'(reg_q[2*32 +: 32]), 512'(32'hDE22BE44), "reg2_strobed");

    // Just past the last register: decode error both ways.
    do_write(BASE + 32'(NREGS) * 32'd4, 32'h12345678, 4'hF, 0, 1, 1);
    do_read(BASE + 32'(NREGS) * 32'd4, 0, 1);
    do_read(BASE - 32'd4, 1, 0);

    // Read-only register rejects writes but reads normally.
    do_write(BASE + 32'h4, 32'h5, 4'hF, 1, 0, 1);
    chk(512'(reg_q[1*32 +: 32]), 512'(0), "ro_reg1_unchanged");
    do_read(BASE + 32'h4, 0, 0);

    // Long BREADY stall.
    do_write(BASE + 32'h10, 32'hA5A5_5A5A, 4'hF, 0, 0, 5);

    // Same-edge commit and AR capture on reg3.
    do_write(BASE + 32'hC, 32'h0000_0033, 4'hF, 0, 0, 1);
    fork
      do_write(BASE + 32'hC, 32'hCAFE_F00D, 4'hF, 0, 0, 1);
      do_read(BASE + 32'hC, 1, 0);
    join
    do_read(BASE + 32'hC, 0, 0);
    chk(512'(reg_q[3*32 +: 32]), 512'(32'hCAFEF00D), "reg3_new");

    // Zero strobes still acknowledge and pulse; unaligned read ignores the low bits.
    do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 0, 0, 1);
    do_read(BASE + 32'hB, 0, 0);

    // Reset while AW is held drops it: a later lone W must not complete a write.
    send_aw(BASE + 32'h14, 0);
    @(posedge clk); #1;
    chk(512'(BVALID), 512'(0), "aw_only_no_b");
    ARESET = 1'b1;
    @(posedge clk); #1;
    ARESET = 1'b0;
    mdl_clear();
    chk(reg_q, mdl_packed(), "regs_after_reset");
    send_w(32'h0000_0077, 4'hF, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk(512'(BVALID), 512'(0), "no_b_after_reset");
    end
    chk(reg_q, mdl_packed(), "no_write_after_reset");
    ARESET = 1'b1;
    @(posedge clk); #1;
    ARESET = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic, including overlapping reads and writes.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] wa, ra, wdat;
      logic [3:0]  ws;
      int          sel;
      wa   = rand_addr();
      ra   = rand_addr();
      wdat = $urandom;
      ws   = 4'($urandom_range(0, 15));
      sel  = int'($urandom_range(0, 2));
      case (sel)
        0: do_write(wa, wdat, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        1: do_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        default: fork
          do_write(wa, wdat, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)));
          do_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        join
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
